// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit: FSM state encoding,
// SRAM geometry and default configuration values.
package mem_pkg;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

  localparam logic [31:0] ADDR_BASE_DEFAULT   = 32'd1024;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_t;

  // Half-word SRAM address for one phase of a word access.
  function automatic logic [SRAM_AW-1:0] half_addr(input logic [SRAM_AW-2:0] word,
                                                   input logic upper);
    return {word, upper};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Off-chip SRAM bus between the access unit (master) and the memory (slave).
interface mem_access_unit_if;
  import mem_pkg::*;

  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic               SRAM_WE_N;
  logic [SRAM_DW-1:0] SRAM_DQ_OUT;
  logic               SRAM_DQ_OE;
  logic [SRAM_DW-1:0] SRAM_DQ_IN;

  modport master (
    output SRAM_ADDR,
    output SRAM_WE_N,
    output SRAM_DQ_OUT,
    output SRAM_DQ_OE,
    input  SRAM_DQ_IN
  );

  modport slave (
    input  SRAM_ADDR,
    input  SRAM_WE_N,
    input  SRAM_DQ_OUT,
    input  SRAM_DQ_OE,
    output SRAM_DQ_IN
  );

endinterface

// File: rtl/mem_access_unit_sram_phase_timer.sv
// Wait-state timer for one SRAM half-word phase. Loaded with WAIT_CYCLES on
// phase entry; phase_last flags the final cycle of the phase.
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_last
);

  localparam logic [2:0] LOAD_VAL = 3'(WAIT_CYCLES);

  logic [2:0] count;

  // Down-counter: reload on phase entry, otherwise count to zero and hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 3'd1;
    end
  end

  assign phase_last = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: each 32-bit load/store is split into two 16-bit
// SRAM phases (low half, then high half) while the pipeline is frozen.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (rejects misaligned or
// below-base addresses and reports addr_err instead of touching SRAM).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ST_val,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              freeze,
  output logic              addr_err,
  mem_access_unit_if.master sram
);

  mem_state_t         state;
  logic               req;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word_addr;
  logic               violation;
  logic               op_write;
  logic [SRAM_AW-2:0] addr_q;
  logic [15:0]        st_hi_q;
  logic               timer_load;
  logic               phase_last;
  logic               unused_addr_bits;

  assign req = MEM_R_EN | MEM_W_EN;

  // Byte address relative to the data-memory base; bits above the SRAM
  // word range are dropped so out-of-range addresses wrap.
  assign offset           = ALU_result - ADDR_BASE;
  assign word_addr        = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;
  assign violation = (ALU_result < ADDR_BASE) | (ALU_result[1:0] != 2'b00);
  assign addr_err  = (state == DONE) & err_q;
`else
  assign violation = 1'b0;
  assign addr_err  = 1'b0;
`endif

  assign ready  = (state == DONE) | ((state == IDLE) & ~req);
  assign freeze = req & ~ready;

  // Reload the wait-state timer on entry to each half-word phase.
  assign timer_load = ((state == IDLE) & req & ~violation) |
                      ((state == LOW) & phase_last);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .phase_last(phase_last)
  );

  // Access FSM with registered SRAM strobes; read halves are captured on the
  // last cycle of their phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      op_write         <= 1'b0;
      addr_q           <= '0;
      st_hi_q          <= '0;
      read_data        <= '0;
      sram.SRAM_ADDR   <= '0;
      sram.SRAM_WE_N   <= 1'b1;
      sram.SRAM_DQ_OUT <= '0;
      sram.SRAM_DQ_OE  <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q            <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_write <= MEM_W_EN;
            addr_q   <= word_addr;
            st_hi_q  <= ST_val[31:16];
`ifdef MEM_BOUNDS_CHECK_EN
            err_q    <= violation;
`endif
            if (violation) begin
              state     <= DONE;
              read_data <= '0;
            end else begin
              state            <= LOW;
              sram.SRAM_ADDR   <= half_addr(word_addr, 1'b0);
              sram.SRAM_WE_N   <= ~MEM_W_EN;
              sram.SRAM_DQ_OE  <= MEM_W_EN;
              sram.SRAM_DQ_OUT <= ST_val[15:0];
            end
          end
        end
        LOW: begin
          if (phase_last) begin
            if (!op_write) begin
              read_data[15:0] <= sram.SRAM_DQ_IN;
            end
            state            <= HIGH;
            sram.SRAM_ADDR   <= half_addr(addr_q, 1'b1);
            sram.SRAM_DQ_OUT <= st_hi_q;
          end
        end
        HIGH: begin
          if (phase_last) begin
            if (!op_write) begin
              read_data[31:16] <= sram.SRAM_DQ_IN;
            end
            state           <= DONE;
            sram.SRAM_WE_N  <= 1'b1;
            sram.SRAM_DQ_OE <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued when
// a request is driven and checked when the unit reports ready on a request.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic        is_load;
    logic [31:0] rd;
    int unsigned start;
    int unsigned lat;
    logic        err;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] ALU_result = '0, ST_val = '0;
  logic [31:0] read_data;
  logic        ready, freeze, addr_err;

  logic        re0 = 1'b0;
  logic [31:0] alu0 = '0;
  logic [31:0] read_data0;
  logic        ready0, freeze0, addr_err0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned last_done_cyc = 0;
  logic        done_seen   = 1'b0;
  logic        we_low_seen = 1'b0;
  sb_item_t    sb[$];

  logic [15:0]        mem [0:(1<<SRAM_AW)-1];
  logic               poke = 1'b0;
  logic [SRAM_AW-1:0] poke_addr = '0;
  logic [15:0]        poke_data = '0;

  mem_access_unit_if sram_bus ();
  mem_access_unit_if sram_bus0 ();

  mem_access_unit #(.WAIT_CYCLES(2), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .ST_val(ST_val), .read_data(read_data),
    .ready(ready), .freeze(freeze), .addr_err(addr_err), .sram(sram_bus.master)
  );

  mem_access_unit #(.WAIT_CYCLES(0), .ADDR_BASE(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(re0), .MEM_W_EN(1'b0),
    .ALU_result(alu0), .ST_val(32'h0), .read_data(read_data0),
    .ready(ready0), .freeze(freeze0), .addr_err(addr_err0), .sram(sram_bus0.master)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write while WE_N is low, asynchronous read.
  always @(posedge clk) begin
    if (poke) mem[poke_addr] <= poke_data;
    else if (!sram_bus.SRAM_WE_N) mem[sram_bus.SRAM_ADDR] <= sram_bus.SRAM_DQ_OUT;
  end
  assign sram_bus.SRAM_DQ_IN = mem[sram_bus.SRAM_ADDR];

  // Second SRAM returns its own half-word address as data.
  assign sram_bus0.SRAM_DQ_IN = sram_bus0.SRAM_ADDR[15:0] + {14'b0, sram_bus0.SRAM_ADDR[17:16]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard when the unit reports ready on a request.
  always @(negedge clk) begin
    if (rst && !sram_bus.SRAM_WE_N) we_low_seen = 1'b1;
    if (rst && ready && (MEM_R_EN || MEM_W_EN)) begin
      check_eq("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        sb_item_t e;
        e = sb.pop_front();
        check_eq("latency", cyc - e.start, e.lat);
        check_eq("addr_err", 32'(addr_err), 32'(e.err));
        check_eq("freeze_done", 32'(freeze), 32'd0);
        if (e.is_load) check_eq("read_data", read_data, e.rd);
        last_done_cyc = cyc;
        done_seen = 1'b1;
      end
    end
  end

  task automatic issue(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd,
                       input int unsigned lat, input logic exp_err);
    sb_item_t e;
    e.is_load = re & ~we;
    e.rd      = exp_rd;
    e.start   = cyc;
    e.lat     = lat;
    e.err     = exp_err;
    sb.push_back(e);
    done_seen  = 1'b0;
    MEM_W_EN   = we;
    MEM_R_EN   = re;
    ALU_result = addr;
    ST_val     = data;
  endtask

  // Waits for the monitor to see completion, then returns just after the DONE edge.
  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("done_in_budget", 32'(done_seen), 32'd1);
    if (!done_seen) sb.delete();
    #1;
  endtask

  task automatic go_idle(input int unsigned cycles);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first_start;
    // Preload the load-test data while in reset.
    poke = 1'b1; poke_addr = 18'd2; poke_data = 16'h1234;
    @(posedge clk); #1;
    poke_addr = 18'd3; poke_data = 16'hABCD;
    @(posedge clk); #1;
    poke = 1'b0;
    @(negedge clk);
    check_eq("rst_read_data", read_data, 32'h0);
    check_eq("rst_sram_addr", 32'(sram_bus.SRAM_ADDR), 32'h0);
    check_eq("rst_we_n", 32'(sram_bus.SRAM_WE_N), 32'd1);
    check_eq("rst_dq_oe", 32'(sram_bus.SRAM_DQ_OE), 32'd0);
    check_eq("rst_dq_out", 32'(sram_bus.SRAM_DQ_OUT), 32'h0);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_freeze", 32'(freeze), 32'd0);
    check_eq("rst_addr_err", 32'(addr_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // W=0 unit with no request: ready high, freeze low every cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("w0_idle_ready", 32'(ready0), 32'd1);
      check_eq("w0_idle_freeze", 32'(freeze0), 32'd0);
    end
    @(posedge clk); #1;
    // W=0 load: ready at cycle 3.
    re0 = 1'b1; alu0 = 32'd1028;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check_eq("w0_ready", 32'(ready0), 32'(k == 3));
      check_eq("w0_freeze", 32'(freeze0), 32'(k != 3));
      if (k == 3) check_eq("w0_read_data", read_data0, 32'h0003_0002);
    end
    @(posedge clk); #1;
    re0 = 1'b0;

    // Load of the preloaded word; WE_N must never go low.
    we_low_seen = 1'b0;
    issue(1'b0, 1'b1, 32'd1028, 32'h0, 32'hABCD_1234, 7, 1'b0);
    wait_done(20);
    check_eq("ld_no_strobe", 32'(we_low_seen), 32'd0);
    go_idle(2);

    // Store with per-cycle SRAM bus checks.
    issue(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 32'h0, 7, 1'b0);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      check_eq("st_freeze", 32'(freeze), 32'(k < 7));
      if (k >= 1 && k <= 6) begin
        check_eq("st_addr", 32'(sram_bus.SRAM_ADDR), (k <= 3) ? 32'd2 : 32'd3);
        check_eq("st_dq_out", 32'(sram_bus.SRAM_DQ_OUT), (k <= 3) ? 32'h0000_BEEF : 32'h0000_DEAD);
        check_eq("st_we_n", 32'(sram_bus.SRAM_WE_N), 32'd0);
        check_eq("st_dq_oe", 32'(sram_bus.SRAM_DQ_OE), 32'd1);
      end
    end
    @(posedge clk); #1;
    go_idle(2);

    // Back-to-back store then load at the base address.
    first_start = cyc;
    issue(1'b1, 1'b0, 32'd1024, 32'h5AC3_0FF0, 32'h0, 7, 1'b0);
    wait_done(20);
    issue(1'b0, 1'b1, 32'd1024, 32'h0, 32'h5AC3_0FF0, 7, 1'b0);
    wait_done(20);
    check_eq("b2b_total", last_done_cyc - first_start + 1, 32'd16);
    go_idle(2);

    // Reset in the middle of a store (cycle 4) aborts to idle.
    MEM_W_EN = 1'b1; ALU_result = 32'd1040; ST_val = 32'h1111_2222;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_we_n", 32'(sram_bus.SRAM_WE_N), 32'd1);
    check_eq("abort_dq_oe", 32'(sram_bus.SRAM_DQ_OE), 32'd0);
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEAD_BEEF, 7, 1'b0);
    wait_done(20);
    go_idle(2);

`ifdef MEM_BOUNDS_CHECK_EN
    // Misaligned and below-base loads complete immediately with addr_err.
    we_low_seen = 1'b0;
    issue(1'b0, 1'b1, 32'd1026, 32'h0, 32'h0, 1, 1'b1);
    wait_done(10);
    go_idle(1);
    issue(1'b0, 1'b1, 32'd512, 32'h0, 32'h0, 1, 1'b1);
    wait_done(10);
    check_eq("bc_no_strobe", 32'(we_low_seen), 32'd0);
    go_idle(2);
`endif

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit of the five-stage ARM-subset pipeline. Consumes the execute stage's ALU_result as a byte address, and the store value and MEM_R_EN/MEM_W_EN from the EXE/MEM register. Performs each 32-bit load or store as two 16-bit accesses to the off-chip SRAM and holds the pipeline frozen until the word transfer completes. It is the reader/writer at the far end of the address and data path the execute stage produces.

## Interface
- WAIT_CYCLES, 2, extra SRAM wait states per half-word phase (0..7)
- ADDR_BASE, 1024, byte address of data-memory word 0
- clk  in  1  pipeline clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- ALU_result  in  32  byte address from execute stage
- ST_val  in  32  store data (Val_Rm)
- read_data  out  32  loaded word, valid when ready=1 on a load
- ready  out  1  access complete / no access pending
- freeze  out  1  pipeline stall = (MEM_R_EN|MEM_W_EN) & ~ready
- addr_err  out  1  bounds violation, only with MEM_BOUNDS_CHECK_EN, else constant 0
- SRAM_ADDR  out  18  half-word address
- SRAM_WE_N  out  1  active-low write strobe
- SRAM_DQ_OUT  out  16  write data
- SRAM_DQ_OE  out  1  data-bus drive enable (tristate at top level)
- SRAM_DQ_IN  in  16  read data

## Operation
- word = (ALU_result − ADDR_BASE) >> 2, 32-bit unsigned subtract. Low phase SRAM_ADDR = {word[16:0],0}. High phase SRAM_ADDR = {word[16:0],1}. Upper bits are discarded (wrap).
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: when MEM_R_EN|MEM_W_EN, latch address, ST_val and op, then go to LOW. Else stay. If both enables are high, perform a write.
- LOW: lasts WAIT_CYCLES+1 cycles, then go to HIGH. Wait counter resets on each phase entry.
- HIGH: lasts WAIT_CYCLES+1 cycles, then go to DONE.
- DONE: one cycle, then IDLE.
- ready = 1 in DONE, and in IDLE with no request. Otherwise 0.
- Write phases:
  - SRAM_WE_N=0 and SRAM_DQ_OE=1 for every cycle of the phase.
  - Low phase drives ST_val[15:0]; high phase drives ST_val[31:16].
- Read phases:
  - SRAM_WE_N=1, SRAM_DQ_OE=0.
  - SRAM_DQ_IN is sampled on the last cycle of the phase into read_data[15:0] (low) or read_data[31:16] (high).
- read_data holds its value until the next load overwrites it.
- Requests dropping mid-access are ignored; the access always completes.
- Outside LOW/HIGH: SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR holds its last value.

## Timing
- Reset values: state IDLE, read_data 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_DQ_OE 0, SRAM_DQ_OUT 0, addr_err 0. ready=1 and freeze=0 while there is no request.
- Reset mid-access aborts immediately to IDLE. A partial write is allowed in SRAM.
- Timing of one access, with the request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W+1.
  - HIGH occupies cycles W+2..2W+2.
  - DONE (ready=1) is cycle 2W+3, so freeze is high for 2W+3 cycles.
  - With W=2, ready is asserted at cycle 7.
- In DONE the pipeline advances at the clock edge. A request present in the following IDLE cycle starts a new access; there are no back-to-back DONE cycles.
- ready, freeze and addr_err are combinational from state and the enables. All SRAM outputs are registered.

## Configuration
- MEM_BOUNDS_CHECK_EN defined: the check runs in IDLE on a request.
  - A violation is ALU_result < ADDR_BASE, or ALU_result[1:0] ≠ 0.
  - On a violation the FSM skips LOW/HIGH and goes straight to DONE. No SRAM strobe is issued, read_data is set to 0, and addr_err=1 during DONE.
  - The violating access therefore freezes the pipeline for 1 cycle.
- MEM_BOUNDS_CHECK_EN undefined: no check, addr_err tied 0, address wraps as above.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE/LOW/HIGH/DONE)
  - SRAM_AW=18 and SRAM_DW=16
  - the ADDR_BASE default of 1024
- One sub-module, sram_phase_timer: a 3-bit down-counter loaded with WAIT_CYCLES on phase entry, with a phase_last output.
- Address subtract, FSM and data latches live in mem_access_unit.

## Test plan
- Store, W=2: ALU_result=1028, ST_val=0xDEADBEEF, MEM_W_EN=1.
  - Cycles 1–3: SRAM_ADDR=2, DQ_OUT=0xBEEF, WE_N=0.
  - Cycles 4–6: SRAM_ADDR=3, DQ_OUT=0xDEAD.
  - ready=1 at cycle 7; freeze high for cycles 0–6.
- Load: SRAM model returns 0x1234 at addr 2 and 0xABCD at addr 3; MEM_R_EN=1, ALU_result=1028 → read_data=0xABCD1234 at cycle 7, WE_N never 0.
- Back-to-back: store then load at ALU_result=1024 in consecutive instructions → second access starts the cycle after DONE; total 16 cycles; the load returns the stored data.
- W=0 parameter: a load completes with ready at cycle 3; no request → ready=1, freeze=0 continuously.
- rst=0 at cycle 4 of a store → next cycle state IDLE, WE_N=1, DQ_OE=0; a new request after reset starts cleanly.
- With MEM_BOUNDS_CHECK_EN:
  - ALU_result=1026 load → addr_err=1 and ready=1 at cycle 1, no SRAM strobe, read_data=0.
  - ALU_result=512 behaves the same way.
